// File: rtl/select_n_antitokens_if.sv
// Handshake bundle for the N-way antitoken select: sel, data channels, result and status.
// The master modport belongs to the producer/consumer side, the slave modport to the select block.
interface select_n_antitokens_if #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_TYPE  = 32,
  parameter int SEL_TYPE   = $clog2(NUM_INPUTS)
);
  logic [SEL_TYPE-1:0]             sel;
  logic                            sel_valid;
  logic                            sel_ready;
  logic [NUM_INPUTS*DATA_TYPE-1:0] ins;
  logic [NUM_INPUTS-1:0]           ins_valid;
  logic [NUM_INPUTS-1:0]           ins_ready;
  logic [DATA_TYPE-1:0]            result;
  logic                            result_valid;
  logic                            result_ready;
  logic [NUM_INPUTS-1:0]           antitoken_pending;

  modport master (
    output sel, sel_valid, ins, ins_valid, result_ready,
    input  sel_ready, ins_ready, result, result_valid, antitoken_pending
  );

  modport slave (
    input  sel, sel_valid, ins, ins_valid, result_ready,
    output sel_ready, ins_ready, result, result_valid, antitoken_pending
  );
endinterface

// File: rtl/select_n_antitokens.sv
// N-way dataflow select; unselected channels get antitokens that cancel their next token.
// Zero-latency combinational handshake; only the per-channel saturating antitoken counters are state.
module select_n_antitokens #(
  parameter int NUM_INPUTS     = 4,
  parameter int DATA_TYPE      = 32,
  parameter int SEL_TYPE       = $clog2(NUM_INPUTS),
  parameter int MAX_ANTITOKENS = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  select_n_antitokens_if.slave  bus
);
  localparam int CNT_W = $clog2(MAX_ANTITOKENS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_ANTITOKENS);

  logic [CNT_W-1:0]      r_cnt [NUM_INPUTS];

  logic [NUM_INPUTS-1:0] w_hit;
  logic [NUM_INPUTS-1:0] w_kill;
  logic [NUM_INPUTS-1:0] w_gen;
  logic [NUM_INPUTS-1:0] w_zero;
  logic                  w_stall;
  logic                  w_cur_valid;
  logic                  w_cur_zero;
  logic                  w_rv;
  logic                  w_fire;

  // Channel decode; an out-of-range sel hits nothing and so never fires.
  always_comb begin
    w_hit       = '0;
    w_kill      = '0;
    w_zero      = '0;
    w_stall     = 1'b0;
    w_cur_valid = 1'b0;
    w_cur_zero  = 1'b0;
    bus.result  = '0;
    for (int j = 0; j < NUM_INPUTS; j++) begin
      w_hit[j]  = (bus.sel == SEL_TYPE'(j));
      w_zero[j] = (r_cnt[j] == '0);
      w_kill[j] = bus.ins_valid[j] & ~w_zero[j];
      if (w_hit[j]) begin
        w_cur_valid = bus.ins_valid[j];
        w_cur_zero  = w_zero[j];
        bus.result  = bus.ins[j*DATA_TYPE +: DATA_TYPE];
      end else begin
        // A valid token this cycle frees a slot, so a full counter only blocks when idle.
        w_stall = w_stall | ((r_cnt[j] == CNT_MAX) & ~bus.ins_valid[j]);
      end
    end
  end

  assign w_rv   = bus.sel_valid & (|w_hit) & w_cur_valid & w_cur_zero & ~w_stall;
  assign w_fire = w_rv & bus.result_ready;

  assign bus.result_valid = w_rv;
  assign bus.sel_ready    = ~bus.sel_valid | w_fire;

  always_comb begin
    bus.ins_ready         = '0;
    bus.antitoken_pending = '0;
    w_gen                 = '0;
    for (int j = 0; j < NUM_INPUTS; j++) begin
      bus.ins_ready[j] = ~bus.ins_valid[j] | w_kill[j] | (w_fire & (w_hit[j] | w_zero[j]));
      // A fresh token already waiting on an unselected channel is absorbed instead of owed.
      w_gen[j]         = w_fire & ~w_hit[j] & ~(bus.ins_valid[j] & w_zero[j]);
      bus.antitoken_pending[j] = ~w_zero[j];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int j = 0; j < NUM_INPUTS; j++) begin
        r_cnt[j] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_INPUTS; j++) begin
        if (w_kill[j] && !w_gen[j]) begin
          r_cnt[j] <= r_cnt[j] - CNT_ONE;
        end else if (!w_kill[j] && w_gen[j]) begin
          r_cnt[j] <= r_cnt[j] + CNT_ONE;
        end
      end
    end
  end
endmodule
